adder: RTL and testbench

Parameterised unsigned binary adder producing a BITS-wide sum and a carry-out from two BITS-wide operands. The primary result path is purely combinational, built as a ripple-carry chain of per-bit full adders. A registered copy of the result is also provided for consumers on the i_clock domain. The block is a leaf arithmetic primitive used by datapath blocks that need an n-bit add with carry.

---
 rtl/adder_if.sv | 34 +++
 rtl/adder.sv | 45 ++++
 tb/tb_adder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_if.sv
// Operand/result bundle for the ripple-carry adder.
// The master side drives the operands and observes the results;
// the slave side is the adder itself.
interface adder_if #(
    parameter int BITS = 4
);
    logic [BITS-1:0] i_augend;
    logic [BITS-1:0] i_addend;
    logic [BITS-1:0] o_sum;
    logic            o_carry;
    logic            o_overflow;
    logic [BITS-1:0] o_sum_reg;
    logic            o_carry_reg;

    modport master (
        output i_augend,
        output i_addend,
        input  o_sum,
        input  o_carry,
        input  o_overflow,
        input  o_sum_reg,
        input  o_carry_reg
    );

    modport slave (
        input  i_augend,
        input  i_addend,
        output o_sum,
        output o_carry,
        output o_overflow,
        output o_sum_reg,
        output o_carry_reg
    );
endinterface

// File: rtl/adder.sv
// Unsigned BITS-wide ripple-carry adder with carry-out and two's-complement
// overflow. The combinational result is also captured in a register on
// i_clock for consumers that want a flopped value.
module adder #(
    parameter int BITS = 4
) (
    input  logic    i_clock,
    input  logic    i_reset,
    adder_if.slave  bus
);
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] s;
    logic [BITS:0]   c;

    assign a    = bus.i_augend;
    assign b    = bus.i_addend;
    assign c[0] = 1'b0;

    // One full adder per bit; carry ripples from bit 0 upward.
    // NOTE: the chain is built from continuous assigns, so every net has
    // exactly one driver and no partial assignment can infer a latch.
    for (genvar k = 0; k < BITS; k++) begin : g_fa
        assign s[k]   = a[k] ^ b[k] ^ c[k];
        assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end

    assign bus.o_sum      = s;
    assign bus.o_carry    = c[BITS];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign bus.o_overflow = c[BITS] ^ c[BITS-1];

    // Registered copy of the result, cleared asynchronously by i_reset.
    // NOTE: non-blocking assignments keep the flop update order-independent;
    // reset touches only these result flops, the adder path is unaffected.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bus.o_sum_reg   <= '0;
            bus.o_carry_reg <= 1'b0;
        end else begin
            bus.o_sum_reg   <= s;
            bus.o_carry_reg <= c[BITS];
        end
    end
endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at BITS = 1, 4 and 8. Expected values come
// from integer arithmetic: unsigned sum for {carry,sum}, signed range test
// for overflow.
module tb_adder;
    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    int errors = 0;
    int checks = 0;

    adder_if #(.BITS(1)) bus1 ();
    adder_if #(.BITS(4)) bus4 ();
    adder_if #(.BITS(8)) bus8 ();

    adder #(.BITS(1)) dut1 (.i_clock(i_clock), .i_reset(i_reset), .bus(bus1));
    adder #(.BITS(4)) dut4 (.i_clock(i_clock), .i_reset(i_reset), .bus(bus4));
    adder #(.BITS(8)) dut8 (.i_clock(i_clock), .i_reset(i_reset), .bus(bus8));

    always #5 i_clock = ~i_clock;

    // Reference overflow: interpret both operands as signed BITS-wide values
    // and report whether their true sum falls outside the signed range.
    function automatic logic ovf_ref(input int bits, input int x, input int y);
        int half, sx, sy, s;
        half = 1 << (bits - 1);
        sx = (x >= half) ? x - 2 * half : x;
        sy = (y >= half) ? y - 2 * half : y;
        s  = sx + sy;
        return (s > half - 1) || (s < -half);
    endfunction

    task automatic drive4(input int x, input int y);
        bus4.i_augend = 4'(x);
        bus4.i_addend = 4'(y);
        #1;
    endtask

    task automatic test_reset();
        drive4(9, 9);
        repeat (2) @(posedge i_clock);
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd0) begin
            errors++;
            $display("FAIL reset_reg4: got %0d, expected 0", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        checks++;
        if ({bus1.o_carry_reg, bus1.o_sum_reg, bus8.o_carry_reg, bus8.o_sum_reg} !== 11'd0) begin
            errors++;
            $display("FAIL reset_reg1_8: got %0h, expected 0",
                     {bus1.o_carry_reg, bus1.o_sum_reg, bus8.o_carry_reg, bus8.o_sum_reg});
        end
        checks++;
        if ({bus4.o_carry, bus4.o_sum} !== 5'd18) begin
            errors++;
            $display("FAIL comb_during_reset: got %0d, expected 18", {bus4.o_carry, bus4.o_sum});
        end
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd18) begin
            errors++;
            $display("FAIL reset_release_load: got %0d, expected 18", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
    endtask

    task automatic test_exhaustive4();
        logic [4:0] e;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                drive4(x, y);
                e = 5'(x + y);
                checks++;
                if ({bus4.o_carry, bus4.o_sum} !== e) begin
                    errors++;
                    $display("FAIL exhaust4 [%0d + %0d]: Expected %0d but result was %0d",
                             x, y, e, {bus4.o_carry, bus4.o_sum});
                end
                checks++;
                if (bus4.o_overflow !== ovf_ref(4, x, y)) begin
                    errors++;
                    $display("FAIL ovf4 [%0d + %0d]: got %b, expected %b",
                             x, y, bus4.o_overflow, ovf_ref(4, x, y));
                end
            end
        end
    endtask

    task automatic test_boundary();
        int xs[3] = '{15, 15, 0};
        int ys[3] = '{1, 15, 0};
        logic [3:0] es[3] = '{4'd0, 4'd14, 4'd0};
        logic       ec[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive4(xs[i], ys[i]);
            checks++;
            if (bus4.o_sum !== es[i] || bus4.o_carry !== ec[i]) begin
                errors++;
                $display("FAIL boundary [%0d + %0d]: got sum=%0d carry=%b, expected sum=%0d carry=%b",
                         xs[i], ys[i], bus4.o_sum, bus4.o_carry, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int   xs[4] = '{7, 8, 15, 3};
        int   ys[4] = '{1, 8, 1, 4};
        logic eo[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive4(xs[i], ys[i]);
            checks++;
            if (bus4.o_overflow !== eo[i]) begin
                errors++;
                $display("FAIL overflow [%0d + %0d]: got %b, expected %b",
                         xs[i], ys[i], bus4.o_overflow, eo[i]);
            end
        end
        drive4(8, 8);
        checks++;
        if ({bus4.o_carry, bus4.o_sum} !== 5'b1_0000) begin
            errors++;
            $display("FAIL overflow_8p8_sum: got %0d, expected 16", {bus4.o_carry, bus4.o_sum});
        end
    endtask

    task automatic test_registered();
        @(negedge i_clock);
        drive4(5, 6);
        @(posedge i_clock);
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd11) begin
            errors++;
            $display("FAIL reg_edge1: got %0d, expected 11", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        @(negedge i_clock);
        drive4(9, 9);
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd11) begin
            errors++;
            $display("FAIL reg_hold: got %0d, expected 11", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        @(posedge i_clock);
        #1;
        checks++;
        if (bus4.o_carry_reg !== 1'b1 || bus4.o_sum_reg !== 4'd2) begin
            errors++;
            $display("FAIL reg_edge2: got carry=%b sum=%0d, expected carry=1 sum=2",
                     bus4.o_carry_reg, bus4.o_sum_reg);
        end
    endtask

    task automatic test_async_reset();
        @(negedge i_clock);
        #2;
        i_reset = 1'b1;
        drive4(3, 4);
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd0) begin
            errors++;
            $display("FAIL async_clear: got %0d, expected 0", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        @(posedge i_clock);
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold_edge: got %0d, expected 0", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd0) begin
            errors++;
            $display("FAIL release_no_edge: got %0d, expected 0", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
        @(posedge i_clock);
        #1;
        checks++;
        if ({bus4.o_carry_reg, bus4.o_sum_reg} !== 5'd7) begin
            errors++;
            $display("FAIL release_load: got %0d, expected 7", {bus4.o_carry_reg, bus4.o_sum_reg});
        end
    endtask

    task automatic test_width1();
        logic [1:0] e;
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                bus1.i_augend = 1'(x);
                bus1.i_addend = 1'(y);
                #1;
                e = 2'(x + y);
                checks++;
                if ({bus1.o_carry, bus1.o_sum} !== e || bus1.o_overflow !== ovf_ref(1, x, y)) begin
                    errors++;
                    $display("FAIL width1 [%0d + %0d]: got carry/sum=%0d ovf=%b, expected %0d ovf=%b",
                             x, y, {bus1.o_carry, bus1.o_sum}, bus1.o_overflow, e, ovf_ref(1, x, y));
                end
            end
        end
    endtask

    task automatic test_width8();
        logic [8:0] e;
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) begin
                bus8.i_augend = 8'(x);
                bus8.i_addend = 8'(y);
                #1;
                e = 9'(x + y);
                checks++;
                if ({bus8.o_carry, bus8.o_sum} !== e || bus8.o_overflow !== ovf_ref(8, x, y)) begin
                    errors++;
                    $display("FAIL width8 [%0d + %0d]: Expected %0d ovf=%b but result was %0d ovf=%b",
                             x, y, e, ovf_ref(8, x, y), {bus8.o_carry, bus8.o_sum}, bus8.o_overflow);
                end
            end
        end
    endtask

    // Random operands on the 8-bit instance; each pair is checked on the
    // combinational path and again on the register after the next edge.
    task automatic test_back_to_back();
        int x, y;
        logic [8:0] e;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clock);
            x = int'($urandom_range(255));
            y = int'($urandom_range(255));
            bus8.i_augend = 8'(x);
            bus8.i_addend = 8'(y);
            e = 9'(x + y);
            #1;
            checks++;
            if ({bus8.o_carry, bus8.o_sum} !== e) begin
                errors++;
                $display("FAIL rand_comb [%0d + %0d]: got %0d, expected %0d",
                         x, y, {bus8.o_carry, bus8.o_sum}, e);
            end
            @(posedge i_clock);
            #1;
            checks++;
            if ({bus8.o_carry_reg, bus8.o_sum_reg} !== e) begin
                errors++;
                $display("FAIL rand_reg [%0d + %0d]: got %0d, expected %0d",
                         x, y, {bus8.o_carry_reg, bus8.o_sum_reg}, e);
            end
        end
    endtask

    initial begin
        bus1.i_augend = '0;
        bus1.i_addend = '0;
        bus4.i_augend = '0;
        bus4.i_addend = '0;
        bus8.i_augend = '0;
        bus8.i_addend = '0;
        test_reset();
        test_exhaustive4();
        test_boundary();
        test_overflow();
        test_registered();
        test_async_reset();
        test_width1();
        test_width8();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
